// File: rtl/snake_body_streamer.sv
// Snake position state: head, body array, move/grow/collision FSM.
// Body entries are streamed one per clock to the graphic stage.
module snake_body_streamer #(
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int X_MAX            = 123,
  parameter int Y_MAX            = 80,
  parameter int START_X          = 60,
  parameter int START_Y          = 40,
  parameter int START_LENGTH     = 2
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        move_tick,
  input  logic [1:0]                  direction,
  input  logic                        grow,
  output logic [6:0]                  snake_head_x,
  output logic [6:0]                  snake_head_y,
  output logic [6:0]                  snake_body_x,
  output logic [6:0]                  snake_body_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_count,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic                        busy,
  output logic                        game_over
);

  localparam int DEPTH = SNAKE_LENGTH_MAX - 1;
  localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX =
    SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 2);
  localparam logic [SNAKE_LENGTH_BIT-1:0] FULL_LEN =
    SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);
  localparam logic [SNAKE_LENGTH_BIT-1:0] INIT_LEN =
    SNAKE_LENGTH_BIT'(START_LENGTH);
  localparam logic [6:0] XM = 7'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT
  } state_t;

  state_t state;

  logic [6:0] body_x [DEPTH];
  logic [6:0] body_y [DEPTH];

  logic [1:0] dir_q;
  logic [1:0] dir_eff;
  logic [6:0] next_x;
  logic [6:0] next_y;
  logic [6:0] nx_q;
  logic [6:0] ny_q;
  logic       grow_q;

  logic [SNAKE_LENGTH_BIT-1:0] scan_k;
  logic [SNAKE_LENGTH_BIT-1:0] tail_idx;
  logic                        occupied;
  logic                        hit;

  // a reversal request would fold the snake onto its neck
  always_comb begin
    dir_eff = direction;
    if (direction[1] == dir_q[1] &&
        direction[0] != dir_q[0])
      dir_eff = dir_q;
  end

  always_comb begin
    next_x = snake_head_x;
    next_y = snake_head_y;
    unique case (dir_eff)
      DIR_UP:
        next_y = (snake_head_y == 7'd0) ?
          YM : snake_head_y - 7'd1;
      DIR_DOWN:
        next_y = (snake_head_y == YM) ?
          7'd0 : snake_head_y + 7'd1;
      DIR_RIGHT:
        next_x = (snake_head_x == XM) ?
          7'd0 : snake_head_x + 7'd1;
      DIR_LEFT:
        next_x = (snake_head_x == 7'd0) ?
          XM : snake_head_x - 7'd1;
      default: ;
    endcase
  end

  // the tail cell only stays occupied when the snake grows
  assign tail_idx = snake_length - 1'b1;
  assign occupied = (scan_k < tail_idx) ||
                    (scan_k == tail_idx && grow_q);
  assign hit = occupied &&
               nx_q == body_x[scan_k] &&
               ny_q == body_y[scan_k];

  assign snake_body_x = body_x[body_count];
  assign snake_body_y = body_y[body_count];

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      snake_head_x <= 7'(START_X);
      snake_head_y <= 7'(START_Y);
      for (int i = 0; i < DEPTH; i++) begin
        body_x[i] <= 7'(START_X - 1 - i);
        body_y[i] <= 7'(START_Y);
      end
      snake_length <= INIT_LEN;
      body_count   <= '0;
      busy         <= 1'b0;
      game_over    <= 1'b0;
      dir_q        <= DIR_RIGHT;
      nx_q         <= '0;
      ny_q         <= '0;
      grow_q       <= 1'b0;
      scan_k       <= '0;
    end else begin
      body_count <= (body_count == LAST_IDX) ?
        '0 : body_count + 1'b1;
      unique case (state)
        IDLE: begin
          if (move_tick && !game_over) begin
            dir_q  <= dir_eff;
            nx_q   <= next_x;
            ny_q   <= next_y;
            grow_q <= grow &&
                      (snake_length != FULL_LEN);
            scan_k <= '0;
            busy   <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (hit) begin
            game_over <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (scan_k == LAST_IDX) begin
            state <= SHIFT;
          end else begin
            scan_k <= scan_k + 1'b1;
          end
        end
        SHIFT: begin
          body_x[0] <= snake_head_x;
          body_y[0] <= snake_head_y;
          for (int i = 1; i < DEPTH; i++) begin
            body_x[i] <= body_x[i-1];
            body_y[i] <= body_y[i-1];
          end
          snake_head_x <= nx_q;
          snake_head_y <= ny_q;
          snake_length <= snake_length +
            {{(SNAKE_LENGTH_BIT-1){1'b0}}, grow_q};
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
